// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and instruction-encoding constants.
package constant;

    localparam logic [3:0] OP_SPECIAL = 4'hF;
    localparam logic [3:0] FUNC_NOOP  = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic is_stop(input logic [31:0] inst);
        return (inst[31:28] == OP_SPECIAL) && (inst[3:0] == FUNC_NOOP);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, inst}; flush empties it and dominates push/pop.
module fetch_queue
    import constant::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && !flush && (count_q != 2'd0);
    assign do_push = push && !flush && ((count_q != 2'd2) || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage is cleared on reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: sequential PC into a 1-cycle BRAM, 2-entry response queue,
// redirects from decode/execute, and halt on an accepted stop instruction.
module fetch
    import constant::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic               f_valid,
    input  logic               f_ready,
    output logic [31:0]        f_pc,
    output logic [31:0]        f_inst,
    input  logic               dec_redirect,
    input  logic [31:0]        dec_target,
    input  logic               ex_redirect,
    input  logic [31:0]        ex_target,
    output logic               halted
);

    fetch_state_t state_q;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  issued_pc_q;
    logic         inflight_q;

    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic [1:0]   q_count;
    logic [2:0]   occupancy;
    logic         run;
    logic         pop;
    logic         ex_take;
    logic         dec_take;
    logic         stop_take;
    logic         flush;
    logic         issue;
    logic         push;

    assign run       = (state_q == ST_RUN);
    assign f_valid   = (q_count != 2'd0);
    assign pop       = f_valid && f_ready;

    // Execute redirect outranks both the decode redirect and a stop being accepted.
    assign ex_take   = run && ex_redirect;
    assign dec_take  = run && pop && dec_redirect && !ex_redirect;
    assign stop_take = run && pop && is_stop(head.inst) && !ex_redirect && !dec_redirect;
    assign flush     = ex_take || dec_take || stop_take;

    // Slots already claimed once this cycle's pop and in-flight response settle.
    assign occupancy = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = run && !flush && (occupancy < 3'd2);
    assign push      = inflight_q && !flush;

    assign push_entry = '{pc: issued_pc_q, inst: imem_data};

    fetch_queue u_queue (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (push_entry),
        .rdata (head),
        .count (q_count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                issued_pc_q <= fetch_pc_q;
                fetch_pc_q  <= fetch_pc_q + 32'd4;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_RUN;
                        fetch_pc_q <= RESET_PC;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ex_take) begin
                        fetch_pc_q <= ex_target & ~32'd3;
                    end else if (dec_take) begin
                        fetch_pc_q <= dec_target & ~32'd3;
                    end else if (stop_take) begin
                        state_q    <= ST_HALT;
                        fetch_pc_q <= head.pc + 32'd4;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_en   = issue;
    assign imem_addr = fetch_pc_q[IMEM_AW+1:2];
    assign f_pc      = head.pc;
    assign f_inst    = head.inst;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: BRAM model, program-order reference model, directed and random stimulus.
module tb_fetch;
    import constant::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        imem_en;
    logic [13:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic        f_valid;
    logic        f_ready = 1'b0;
    logic [31:0] f_pc;
    logic [31:0] f_inst;
    logic        dec_redirect = 1'b0;
    logic [31:0] dec_target = '0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = '0;
    logic        halted;

    logic [31:0] mem [0:16383];
    logic [31:0] stop_word;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pc;
    bit          hold_q;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;

    typedef struct {
        logic [31:0] at_pc;
        bit          dec_en;
        logic [31:0] dec_tgt;
        bit          ex_en;
        logic [31:0] ex_tgt;
        logic [31:0] want_pc;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    fetch #(.RESET_PC(32'h0), .IMEM_AW(14)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .f_valid      (f_valid),
        .f_ready      (f_ready),
        .f_pc         (f_pc),
        .f_inst       (f_inst),
        .dec_redirect (dec_redirect),
        .dec_target   (dec_target),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .halted       (halted)
    );

    always @(posedge clk) begin
        if (imem_en) imem_data <= mem[imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock of the reference model: every accepted instruction must be the next
    // one in program order, and a stalled head must not change.
    task automatic cycle();
        #2;
        if (hold_q) begin
            chk("hold_valid", 32'(f_valid), 32'd1);
            chk("hold_pc", f_pc, hold_pc);
            chk("hold_inst", f_inst, hold_inst);
        end
        hold_q = f_valid && !f_ready && !ex_redirect && rstn;
        hold_pc = f_pc;
        hold_inst = f_inst;
        if (f_valid && f_ready && rstn) begin
            $display("accept pc=%h inst=%h", f_pc, f_inst);
            chk("seq_pc", f_pc, exp_pc);
            chk("seq_inst", f_inst, mem[f_pc[15:2]]);
            exp_pc = f_pc + 32'd4;
            if (dec_redirect) exp_pc = dec_target & ~32'd3;
        end
        if (ex_redirect && rstn) exp_pc = ex_target & ~32'd3;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        start = 1'b0;
        f_ready = 1'b0;
        dec_redirect = 1'b0;
        ex_redirect = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
        hold_q = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_pc(input logic [31:0] pc);
        int n = 0;
        while (!(f_valid && f_pc == pc) && n < 40) begin
            cycle();
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL wait_pc actual=%h required=%h (timeout)", f_pc, pc);
        end
    endtask

    // Called in the cycle after start/redirect: nothing valid for two cycles, then pc.
    task automatic lat3(input logic [31:0] pc);
        #1;
        chk("lat_t1_valid", 32'(f_valid), 32'd0);
        cycle();
        chk("lat_t2_valid", 32'(f_valid), 32'd0);
        cycle();
        chk("lat_t3_valid", 32'(f_valid), 32'd1);
        chk("lat_t3_pc", f_pc, pc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_imem_en"}, 32'(imem_en), 32'd0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_f_valid"}, 32'(f_valid), 32'd0);
        chk({tag, "_f_pc"}, f_pc, 32'd0);
        chk({tag, "_f_inst"}, f_inst, 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stop_word = {OP_SPECIAL, 24'h000000, FUNC_NOOP};
        for (int i = 0; i < 16384; i++) mem[i] = 32'(i * 3);
        hold_q = 1'b0;
        exp_pc = 32'h0;

        vecs[0] = '{32'h8,    1'b1, 32'h100,  1'b0, 32'h0,        32'h100};
        vecs[1] = '{32'h104,  1'b1, 32'h80,   1'b1, 32'h40,       32'h40};
        vecs[2] = '{32'h48,   1'b0, 32'h0,    1'b1, 32'h203,      32'h200};
        vecs[3] = '{32'h200,  1'b1, 32'h1FFE, 1'b0, 32'h0,        32'h1FFC};
        vecs[4] = '{32'h1FFC, 1'b0, 32'h0,    1'b1, 32'hFFFFFFF8, 32'hFFFFFFF8};
        vecs[5] = '{32'h4,    1'b1, 32'h300,  1'b1, 32'h10,       32'h10};

        // Reset values
        @(posedge clk); #1;
        cycle();
        cycle();
        #1;
        chk_reset_outputs("reset");

        // Start latency and streaming
        rstn = 1'b1;
        f_ready = 1'b1;
        exp_pc = 32'h0;
        do_start();
        #1;
        chk("start_t1_imem_en", 32'(imem_en), 32'd1);
        chk("start_t1_imem_addr", 32'(imem_addr), 32'd0);
        cycle();
        chk("start_t2_valid", 32'(f_valid), 32'd0);
        cycle();
        chk("start_t3_valid", 32'(f_valid), 32'd1);
        chk("start_t3_pc", f_pc, 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", 32'(f_valid), 32'd1);
            chk("stream_pc", f_pc, 32'(i * 4));
            cycle();
        end

        // Backpressure: head stays at pc 0 and fetching stops once the queue is full
        do_reset();
        exp_pc = 32'h0;
        do_start();
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(f_valid), 32'd1);
            chk("bp_pc", f_pc, 32'h0);
            chk("bp_imem_en", 32'(imem_en), 32'd0);
            cycle();
        end
        f_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();

        // Redirect table
        do_reset();
        f_ready = 1'b1;
        exp_pc = 32'h0;
        do_start();
        for (int v = 0; v < 6; v++) begin
            wait_pc(vecs[v].at_pc);
            dec_redirect = vecs[v].dec_en;
            dec_target = vecs[v].dec_tgt;
            ex_redirect = vecs[v].ex_en;
            ex_target = vecs[v].ex_tgt;
            cycle();
            dec_redirect = 1'b0;
            ex_redirect = 1'b0;
            lat3(vecs[v].want_pc);
        end
        cycle();
        cycle();

        // Stop, halt, resume; then stop coinciding with an execute redirect
        mem[5] = stop_word;
        mem[9] = stop_word;
        do_reset();
        f_ready = 1'b1;
        exp_pc = 32'h0;
        do_start();
        wait_pc(32'h14);
        cycle();
        #1;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_valid", 32'(f_valid), 32'd0);
        chk("halt_imem_en", 32'(imem_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("halt_stay", 32'(halted), 32'd1);
            chk("halt_stay_valid", 32'(f_valid), 32'd0);
        end
        do_start();
        #1;
        chk("resume_halted", 32'(halted), 32'd0);
        lat3(32'h18);
        wait_pc(32'h24);
        ex_redirect = 1'b1;
        ex_target = 32'h200;
        cycle();
        ex_redirect = 1'b0;
        #1;
        chk("stop_ex_halted", 32'(halted), 32'd0);
        lat3(32'h200);
        cycle();
        cycle();

        // Reset with a read in flight and the queue occupied
        do_reset();
        exp_pc = 32'h0;
        do_start();
        cycle();
        cycle();
        rstn = 1'b0;
        cycle();
        chk_reset_outputs("midreset");
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("post_reset_idle_valid", 32'(f_valid), 32'd0);
        end
        f_ready = 1'b1;
        exp_pc = 32'h0;
        do_start();
        lat3(32'h0);
        chk("post_reset_inst", f_inst, mem[0]);
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic against the program-order model
        mem[5] = 32'd15;
        mem[9] = 32'd27;
        do_reset();
        f_ready = 1'b1;
        exp_pc = 32'h0;
        do_start();
        for (int i = 0; i < 500; i++) begin
            f_ready = ($urandom_range(0, 9) < 7);
            dec_redirect = ($urandom_range(0, 9) == 0);
            dec_target = $urandom_range(0, 4095);
            ex_redirect = ($urandom_range(0, 19) == 0);
            ex_target = $urandom_range(0, 4095);
            start = ($urandom_range(0, 19) == 0);
            cycle();
        end
        dec_redirect = 1'b0;
        ex_redirect = 1'b0;
        start = 1'b0;
        f_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
